// File: rtl/pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dimmer
// Brief    : Multi-channel PWM lamp dimmer. Duty updates are applied only at
//            period wrap, so the outputs never glitch. An optional fade ramp
//            is compiled in with `define PWM_DIMMER_FADE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dimmer #(
    parameter int CHANNELS = 4,
    parameter int RES      = 8,
    parameter int PRESCALE = 64,
    parameter int STEP     = 8
) (
    input  logic                    fst_clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     on,
    input  logic [CHANNELS*RES-1:0] level,
    output logic [CHANNELS-1:0]     light,
    output logic [CHANNELS-1:0]     busy
);

    localparam int                 c_max      = (1 << RES) - 1;
    localparam int                 c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);
    localparam logic [RES-1:0]     c_cnt_last = RES'(c_max - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_STEADY = 2'd1,
        ST_UP     = 2'd2,
        ST_DOWN   = 2'd3
    } ch_state_t;

    generate
        if (CHANNELS < 1 || RES < 2 || RES > 16 || PRESCALE < 1 ||
            STEP < 1 || STEP > c_max) begin : g_bad_param
            $error("pwm_dimmer: illegal parameter set");
        end
    endgenerate

    logic [c_pre_w-1:0]  r_pre;
    logic [RES-1:0]      r_cnt;
    logic [RES-1:0]      r_cur      [CHANNELS];
    logic [CHANNELS-1:0] r_light;
    logic [CHANNELS-1:0] r_busy;

    logic                w_tick;
    logic                w_wrap;
    logic [RES-1:0]      w_tgt      [CHANNELS];
    ch_state_t           w_state    [CHANNELS];
    logic [RES-1:0]      w_cur_next [CHANNELS];

`ifdef PWM_DIMMER_FADE_EN
    localparam logic [RES:0] c_step = (RES+1)'(STEP);
    logic [RES:0] w_up_sum   [CHANNELS];
    logic [RES:0] w_dn_floor [CHANNELS];
`endif

    assign w_tick = (r_pre == c_pre_last);
    assign w_wrap = w_tick && (r_cnt == c_cnt_last);

    // Channel state is a pure function of the duty register against the
    // live target; the duty register is the only per-channel storage.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_tgt[i]      = on[i] ? level[i*RES +: RES] : '0;
            w_state[i]    = ST_OFF;
            w_cur_next[i] = r_cur[i];
`ifdef PWM_DIMMER_FADE_EN
            w_up_sum[i]   = {1'b0, r_cur[i]} + c_step;
            w_dn_floor[i] = {1'b0, w_tgt[i]} + c_step;
`endif
            if (r_cur[i] < w_tgt[i]) begin
                w_state[i] = ST_UP;
            end else if (r_cur[i] > w_tgt[i]) begin
                w_state[i] = ST_DOWN;
            end else if (r_cur[i] != '0) begin
                w_state[i] = ST_STEADY;
            end

            if (w_wrap) begin
                case (w_state[i])
`ifdef PWM_DIMMER_FADE_EN
                    ST_UP: begin
                        if (w_up_sum[i] > {1'b0, w_tgt[i]}) begin
                            w_cur_next[i] = w_tgt[i];
                        end else begin
                            w_cur_next[i] = w_up_sum[i][RES-1:0];
                        end
                    end
                    ST_DOWN: begin
                        // Clamp at the target; since tgt >= 0 this also keeps cur >= 0.
                        if ({1'b0, r_cur[i]} <= w_dn_floor[i]) begin
                            w_cur_next[i] = w_tgt[i];
                        end else begin
                            w_cur_next[i] = r_cur[i] - c_step[RES-1:0];
                        end
                    end
`else
                    ST_UP:   w_cur_next[i] = w_tgt[i];
                    ST_DOWN: w_cur_next[i] = w_tgt[i];
`endif
                    default: w_cur_next[i] = r_cur[i];
                endcase
            end
        end
    end

    always_ff @(posedge fst_clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_cnt   <= '0;
            r_light <= '0;
            r_busy  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cur[i] <= '0;
            end
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
            // cnt never reaches MAX, so cur == MAX yields a constant high.
            for (int i = 0; i < CHANNELS; i++) begin
                r_cur[i]   <= w_cur_next[i];
                r_light[i] <= (r_cnt < r_cur[i]);
                r_busy[i]  <= (w_cur_next[i] != w_tgt[i]);
            end
        end
    end

    assign light = r_light;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_dimmer
// Brief    : Directed self-checking bench for pwm_dimmer (2 ch, RES=4,
//            PRESCALE=2, STEP=4, period 30 cycles); fade or no-fade build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_dimmer;

    logic       fst_clk;
    logic       rst;
    logic [1:0] on;
    logic [7:0] level;
    logic [1:0] light;
    logic [1:0] busy;

    int n_checks;
    int n_fail;
    int cyc;

    pwm_dimmer #(
        .CHANNELS(2),
        .RES     (4),
        .PRESCALE(2),
        .STEP    (4)
    ) dut (
        .fst_clk(fst_clk),
        .rst    (rst),
        .on     (on),
        .level  (level),
        .light  (light),
        .busy   (busy)
    );

    initial fst_clk = 1'b0;
    always #5 fst_clk = ~fst_clk;

    // Edge number since reset release; wraps happen on edges 30, 60, 90, ...
    always @(posedge fst_clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic goto_edge(input int n);
        while (cyc < n) @(negedge fst_clk);
    endtask

    task automatic do_reset(input logic [1:0] on_v, input logic [7:0] level_v);
        rst = 1'b1;
        @(negedge fst_clk);
        @(negedge fst_clk);
        on    = on_v;
        level = level_v;
        rst   = 1'b0;
    endtask

    // Called at the negedge after a wrap edge; samples one full period.
    task automatic measure(output int hi0, output int hi1,
                           output logic [1:0] b_pre, output logic [1:0] b_last);
        hi0 = 0;
        hi1 = 0;
        b_pre  = 2'b00;
        b_last = 2'b00;
        for (int k = 1; k <= 30; k++) begin
            @(negedge fst_clk);
            hi0 += int'(light[0]);
            hi1 += int'(light[1]);
            if (k == 29) b_pre  = busy;
            if (k == 30) b_last = busy;
        end
    endtask

    task automatic test_reset;
        logic exp_b;
        rst = 1'b1; on = 2'b00; level = 8'h00;
        @(negedge fst_clk);
        @(negedge fst_clk);
        n_checks++; if (light !== 2'b00) begin n_fail++; $display("FAIL reset_light: got %b want 00", light); end
        n_checks++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", busy); end

        on = 2'b01; level = 8'h0F;
        rst = 1'b0;
        @(negedge fst_clk);
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_busy_after_req: got %b want 1", busy[0]); end
        goto_edge(30);
        n_checks++; if (light[0] !== 1'b0) begin n_fail++; $display("FAIL reset_dark_before_wrap: got %b want 0", light[0]); end
        goto_edge(36);
        n_checks++; if (light[0] !== 1'b1) begin n_fail++; $display("FAIL reset_lit_mid_ramp: got %b want 1", light[0]); end

        #2 rst = 1'b1;
        #1;
        n_checks++; if (light !== 2'b00) begin n_fail++; $display("FAIL async_reset_light: got %b want 00", light); end
        n_checks++; if (busy !== 2'b00) begin n_fail++; $display("FAIL async_reset_busy: got %b want 00", busy); end

        @(negedge fst_clk);
        rst = 1'b0;
        goto_edge(30);
        n_checks++; if (light[0] !== 1'b0) begin n_fail++; $display("FAIL restart_edge30_light: got %b want 0", light[0]); end
        goto_edge(31);
        n_checks++; if (light[0] !== 1'b1) begin n_fail++; $display("FAIL restart_edge31_light: got %b want 1", light[0]); end
`ifdef PWM_DIMMER_FADE_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        n_checks++; if (busy[0] !== exp_b) begin n_fail++; $display("FAIL restart_busy_after_wrap: got %b want %b", busy[0], exp_b); end
    endtask

    task automatic test_level6;
        int         hi0, hi1;
        logic [1:0] b_pre, b_last;
        int         exp_hi_first;
        logic       exp_b30;
        logic       exp_bpre;
`ifdef PWM_DIMMER_FADE_EN
        exp_hi_first = 8;  exp_b30 = 1'b1; exp_bpre = 1'b1;
`else
        exp_hi_first = 12; exp_b30 = 1'b0; exp_bpre = 1'b0;
`endif
        do_reset(2'b01, 8'h06);
        goto_edge(29);
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL lvl6_busy_pre_wrap: got %b want 1", busy[0]); end
        goto_edge(30);
        n_checks++; if (busy[0] !== exp_b30) begin n_fail++; $display("FAIL lvl6_busy_at_wrap: got %b want %b", busy[0], exp_b30); end
        measure(hi0, hi1, b_pre, b_last);
        n_checks++; if (hi0 !== exp_hi_first) begin n_fail++; $display("FAIL lvl6_period1_high: got %0d want %0d", hi0, exp_hi_first); end
        n_checks++; if (b_pre[0] !== exp_bpre) begin n_fail++; $display("FAIL lvl6_busy_edge59: got %b want %b", b_pre[0], exp_bpre); end
        n_checks++; if (b_last[0] !== 1'b0) begin n_fail++; $display("FAIL lvl6_busy_edge60: got %b want 0", b_last[0]); end
        measure(hi0, hi1, b_pre, b_last);
        n_checks++; if (hi0 !== 12) begin n_fail++; $display("FAIL lvl6_period2_high: got %0d want 12", hi0); end
        n_checks++; if (hi1 !== 0) begin n_fail++; $display("FAIL lvl6_ch1_dark: got %0d want 0", hi1); end
    endtask

    task automatic test_fade_up_down;
        int         hi0, hi1;
        logic [1:0] b_pre, b_last;
`ifdef PWM_DIMMER_FADE_EN
        int   up_hi[4]   = '{8, 16, 24, 30};
        logic up_bl[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic up_bp3     = 1'b1;
        int   dn_hi[4]   = '{22, 14, 6, 0};
        logic dn_bl[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
        int   up_hi[4]   = '{30, 30, 30, 30};
        logic up_bl[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic up_bp3     = 1'b0;
        int   dn_hi[4]   = '{0, 0, 0, 0};
        logic dn_bl[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset(2'b01, 8'h0F);
        goto_edge(30);
        for (int p = 0; p < 4; p++) begin
            measure(hi0, hi1, b_pre, b_last);
            n_checks++; if (hi0 !== up_hi[p]) begin n_fail++; $display("FAIL fade_up_high[%0d]: got %0d want %0d", p, hi0, up_hi[p]); end
            n_checks++; if (b_last[0] !== up_bl[p]) begin n_fail++; $display("FAIL fade_up_busy[%0d]: got %b want %b", p, b_last[0], up_bl[p]); end
            if (p == 2) begin
                n_checks++; if (b_pre[0] !== up_bp3) begin n_fail++; $display("FAIL fade_up_busy_edge119: got %b want %b", b_pre[0], up_bp3); end
            end
        end

        on = 2'b00;
        @(negedge fst_clk);
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b want 1", busy[0]); end
        goto_edge(179);
        n_checks++; if (light[0] !== 1'b1) begin n_fail++; $display("FAIL drop_not_immediate: got %b want 1", light[0]); end
        goto_edge(180);
        for (int p = 0; p < 4; p++) begin
            measure(hi0, hi1, b_pre, b_last);
            n_checks++; if (hi0 !== dn_hi[p]) begin n_fail++; $display("FAIL fade_dn_high[%0d]: got %0d want %0d", p, hi0, dn_hi[p]); end
            n_checks++; if (b_last[0] !== dn_bl[p]) begin n_fail++; $display("FAIL fade_dn_busy[%0d]: got %b want %b", p, b_last[0], dn_bl[p]); end
        end
    endtask

    task automatic test_retarget;
        int         hi0, hi1;
        logic [1:0] b_pre, b_last;
        int         exp_hi1;
        logic       exp_b1;
`ifdef PWM_DIMMER_FADE_EN
        exp_hi1 = 8;  exp_b1 = 1'b1;
`else
        exp_hi1 = 30; exp_b1 = 1'b0;
`endif
        do_reset(2'b01, 8'h08);
        goto_edge(65);
        level = 8'hFA;
        on    = 2'b11;
        @(negedge fst_clk);
        n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL retarget_busy1: got %b want 1", busy[1]); end
        goto_edge(77);
        n_checks++; if (light[0] !== 1'b0) begin n_fail++; $display("FAIL retarget_mid_period_ignored: got %b want 0", light[0]); end
        goto_edge(90);
        measure(hi0, hi1, b_pre, b_last);
        n_checks++; if (hi0 !== 20) begin n_fail++; $display("FAIL retarget_ch0_high: got %0d want 20", hi0); end
        n_checks++; if (hi1 !== exp_hi1) begin n_fail++; $display("FAIL retarget_ch1_high: got %0d want %0d", hi1, exp_hi1); end
        n_checks++; if (b_last !== {exp_b1, 1'b0}) begin n_fail++; $display("FAIL retarget_busy: got %b want %b0", b_last, exp_b1); end
    endtask

    task automatic test_extremes;
        int         hi0, hi1;
        logic [1:0] b_pre, b_last;
        do_reset(2'b11, 8'hF0);
        @(negedge fst_clk);
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL ext_zero_busy: got %b want 0", busy[0]); end
        goto_edge(120);
        measure(hi0, hi1, b_pre, b_last);
        n_checks++; if (hi0 !== 0) begin n_fail++; $display("FAIL ext_zero_high: got %0d want 0", hi0); end
        n_checks++; if (hi1 !== 30) begin n_fail++; $display("FAIL ext_full_high: got %0d want 30", hi1); end
        n_checks++; if (b_last !== 2'b00) begin n_fail++; $display("FAIL ext_busy: got %b want 00", b_last); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        on       = 2'b00;
        level    = 8'h00;
        test_reset;
        test_level6;
        test_fade_up_down;
        test_retarget;
        test_extremes;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
